s2_demux: RTL and testbench
===========================

# s2_demux

Registered 1:4 demultiplexer with per-lane valid/acknowledge handshake, the distribution counterpart of the S2 registered 4:1 selector cell. One N-bit input word per accepted transfer is steered to one of four holding registers Q0..Q3. The destination uses the same select encoding as S2: {A1|B1, A0&B0}. Each lane holds its word until the downstream consumer acknowledges it. The block sits between a single producer and four lane consumers in the logic-module datapath.

## Interface
- N, default 1: data width of the input word and of each lane register.

- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset, synchronous, active-low; clr=0 at a rising edge resets the block.
- din  input  N  input data word.
- in_valid  input  1  producer presents din and a destination select.
- in_ready  output  1  block accepts the word this cycle (combinational).
- A1, B1, A0, B0  input  1 each  destination select. S1 = A1|B1, S0 = A0&B0, lane index = {S1,S0}.
- flush  input  1  synchronous clear of all lanes.
- Q0, Q1, Q2, Q3  output  N each  lane holding registers.
- q_valid  output  4  bit i set means Qi holds an unconsumed word.
- q_ack  input  4  bit i means the consumer takes Qi this cycle; it is effective only when q_valid[i]=1.
- stall_cnt  output  8  stall counter; present only with S2_DEMUX_STALL_CNT_EN.

## Operation
- Lane index decode:
  - S1=0, S0=0: lane 0.
  - S1=0, S0=1: lane 1.
  - S1=1, S0=0: lane 2.
  - S1=1, S0=1: lane 3.
- Each lane is a 2-state FSM, EMPTY or FULL, with q_valid[i] = (state==FULL).
- EMPTY to FULL: write to lane i.
- FULL to EMPTY: q_ack[i]=1 with no write to lane i in the same cycle.
- FULL stays FULL with new data: q_ack[i]=1 and a write to lane i in the same cycle.
- FULL stays FULL, data held: no q_ack[i] and no write.
- in_ready = clr & ~flush & (~q_valid[idx] | q_ack[idx]), where idx is the decoded lane.
- Write: in_valid & in_ready. Q[idx] <= din and lane idx goes FULL. Other lanes are untouched.
- in_valid=0: the select lines are don't-care, and in_ready still reflects the decoded idx.
- q_ack[i] with q_valid[i]=0: ignored, no state change.
- Acks on other lanes apply independently in the same cycle as a write.
- flush=1 at an edge:
  - All lanes go EMPTY and all Q go to 0.
  - No write occurs, since in_ready is forced 0.
  - All acks are ignored.
- Priority: clr=0 over flush, flush over write/ack.
- No data is ever dropped. A word for a FULL, unacked lane waits with in_ready=0.

## Timing
- Reset: clr=0 at an edge gives the following values, held while clr=0:
  - Q0..Q3 = 0, q_valid = 4'b0000, stall_cnt = 0.
  - in_ready = 0 (combinational).
- Reset mid-operation: all lane contents are discarded at the next edge.
- Latency: a word accepted at edge k appears on Q[idx] with q_valid[idx]=1 immediately after edge k. This is one register stage, no combinational din→Q path.
- Ack: q_ack[i] sampled at edge k clears q_valid[i] after edge k. The lane can accept again in the cycle after edge k.
- Back-to-back same-lane streaming at full rate is supported by holding q_ack[i]=1: in_ready stays 1 and Q[i] updates every cycle.
- Back-to-back writes to different empty lanes: one per cycle.
- Handshake: the producer holds din, the select lines and in_valid stable until in_ready=1. Behaviour on withdrawn requests is unspecified but must not corrupt other lanes.

## Configuration
- S2_DEMUX_STALL_CNT_EN defined:
  - The stall_cnt port exists.
  - The 8-bit counter increments at each edge where in_valid=1 and in_ready=0, and clr=1 and flush=0.
  - It saturates at 255.
  - It is cleared by clr=0. flush does not clear it.
- Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: drive clr=0 for 2 cycles with in_valid=1 and din=1. Required: Q0..Q3=0, q_valid=0000, in_ready=0, stall_cnt=0.
- Decode: N=8, write 0x11/0x22/0x33/0x44 with select patterns in order.
  - Patterns: A1B1A0B0 = 0000, 0011, 0100, 1011.
  - Required: Q0=0x11, Q1=0x22, Q2=0x33, Q3=0x44, q_valid=1111.
  - Also: pattern 0010 routes to lane 0.
- Backpressure: lane 2 FULL with 0x33; present 0x55 to lane 2 for 3 cycles, then pulse q_ack[2].
  - During the hold: in_ready=0, Q2 stays 0x33, stall_cnt=3 (macro on).
  - After the ack cycle: Q2=0x55 and q_valid[2]=1.
- Simultaneous: lane 1 FULL with 0x22; assert q_ack[1] and a write of 0x66 to lane 1 in one cycle. Required: Q1=0x66, q_valid[1] stays 1.
- Flush: all lanes FULL; assert flush with in_valid=1 targeting lane 0. Required: q_valid=0000, all Q=0, in_ready=0 during flush, no write.
- Spurious ack: q_ack=1111 with q_valid=0000. Required: no change; the next write to lane 3 is accepted in one cycle.

Source files
------------

// File: rtl/s2_demux_if.sv
// s2_demux_if: producer/consumer bundle for the s2_demux 1:4 registered demux.
//   din, in_valid, A1/B1/A0/B0 : producer word, valid and destination select
//   in_ready                   : block accepts the presented word this cycle
//   flush                      : synchronous clear of all lanes
//   Q0..Q3, q_valid, q_ack     : lane holding registers and per-lane handshake
// master = producer/consumer side, slave = the demux itself.
interface s2_demux_if #(
  parameter int N = 1
);
  logic [N-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic         A1;
  logic         B1;
  logic         A0;
  logic         B0;
  logic         flush;
  logic [N-1:0] Q0;
  logic [N-1:0] Q1;
  logic [N-1:0] Q2;
  logic [N-1:0] Q3;
  logic [3:0]   q_valid;
  logic [3:0]   q_ack;

  modport master (
    output din, in_valid, A1, B1, A0, B0, flush, q_ack,
    input  in_ready, Q0, Q1, Q2, Q3, q_valid
  );

  modport slave (
    input  din, in_valid, A1, B1, A0, B0, flush, q_ack,
    output in_ready, Q0, Q1, Q2, Q3, q_valid
  );
endinterface

// File: rtl/s2_demux.sv
// s2_demux: registered 1:4 demultiplexer with per-lane valid/ack handshake.
// A word accepted on in_valid & in_ready is stored in lane {A1|B1, A0&B0}
// and held there until that lane's consumer acknowledges it.
// Ports:
//   clk       : clock, rising edge
//   clr       : synchronous active-low reset
//   bus       : s2_demux_if slave (din/in_valid/in_ready, select, flush,
//               Q0..Q3, q_valid, q_ack)
//   stall_cnt : saturating 8-bit count of stalled cycles, present only when
//               S2_DEMUX_STALL_CNT_EN is defined
module s2_demux #(
  parameter int N = 1
) (
  input  logic      clk,
  input  logic      clr,
  s2_demux_if.slave bus
`ifdef S2_DEMUX_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t  state_q [4];
  lane_state_t  state_d [4];
  logic [N-1:0] data_q  [4];
  logic [N-1:0] data_d  [4];

  logic [1:0] idx;
  logic       in_ready;
  logic       wr;

  always_comb begin
    idx      = {bus.A1 | bus.B1, bus.A0 & bus.B0};
    // Ack on the target lane frees it in the same cycle, enabling full-rate streaming.
    in_ready = clr & ~bus.flush & ((state_q[idx] == EMPTY) | bus.q_ack[idx]);
    wr       = bus.in_valid & in_ready;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (bus.flush) begin
        state_d[i] = EMPTY;
        data_d[i]  = '0;
      end else if (wr && (idx == 2'(i))) begin
        state_d[i] = FULL;
        data_d[i]  = bus.din;
      end else if (bus.q_ack[i] && (state_q[i] == FULL)) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.Q0       = data_q[0];
  assign bus.Q1       = data_q[1];
  assign bus.Q2       = data_q[2];
  assign bus.Q3       = data_q[3];
  assign bus.q_valid  = {state_q[3] == FULL, state_q[2] == FULL,
                         state_q[1] == FULL, state_q[0] == FULL};

`ifdef S2_DEMUX_STALL_CNT_EN
  logic [7:0] stall_cnt_q;
  logic [7:0] stall_cnt_d;

  // Flush forces in_ready low but is not a stall, so it is excluded here.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid && !in_ready && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_s2_demux.sv
// tb_s2_demux: directed self-checking bench for s2_demux with N=8.
module tb_s2_demux;
  localparam int N = 8;

  logic clk = 1'b0;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  s2_demux_if #(.N(N)) bus ();
`ifdef S2_DEMUX_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  s2_demux #(.N(N)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus.slave)
`ifdef S2_DEMUX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern bits are A1,B1,A0,B0 from MSB to LSB.
  task automatic set_sel(input logic [3:0] p);
    bus.A1 = p[3];
    bus.B1 = p[2];
    bus.A0 = p[1];
    bus.B0 = p[0];
  endtask

  task automatic test_reset();
    clr          = 1'b0;
    bus.in_valid = 1'b1;
    bus.din      = 8'h01;
    bus.flush    = 1'b0;
    bus.q_ack    = 4'b0000;
    set_sel(4'b0000);
    tick();
    tick();
    checks++;
    if ({bus.Q0, bus.Q1, bus.Q2, bus.Q3} !== 32'h0) begin
      errors++;
      $display("FAIL reset_q got %h exp 00000000", {bus.Q0, bus.Q1, bus.Q2, bus.Q3});
    end
    checks++;
    if (bus.q_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_qvalid got %b exp 0000", bus.q_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
    end
`ifdef S2_DEMUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt);
    end
`endif
    bus.in_valid = 1'b0;
    clr          = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [3:0] pats [4];
    logic [7:0] words [4];
    pats  = '{4'b0000, 4'b0011, 4'b0100, 4'b1011};
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      set_sel(pats[i]);
      bus.din      = words[i];
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL decode_ready lane %0d got %b exp 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.Q0, bus.Q1, bus.Q2, bus.Q3} !== 32'h11223344) begin
      errors++;
      $display("FAIL decode_q got %h exp 11223344", {bus.Q0, bus.Q1, bus.Q2, bus.Q3});
    end
    checks++;
    if (bus.q_valid !== 4'b1111) begin
      errors++;
      $display("FAIL decode_qvalid got %b exp 1111", bus.q_valid);
    end
  endtask

  task automatic test_backpressure();
    set_sel(4'b0100);
    bus.din      = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready cycle %0d got %b exp 0", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.Q2 !== 8'h33) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got %h exp 33", i, bus.Q2);
      end
    end
`ifdef S2_DEMUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bp_stall_cnt got %0d exp 3", stall_cnt);
    end
`endif
    bus.q_ack = 4'b0100;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.q_ack    = 4'b0000;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.Q2 !== 8'h55 || bus.q_valid !== 4'b1111) begin
      errors++;
      $display("FAIL bp_after got Q2=%h qv=%b exp Q2=55 qv=1111", bus.Q2, bus.q_valid);
    end
  endtask

  task automatic test_simultaneous();
    set_sel(4'b0011);
    bus.din      = 8'h66;
    bus.in_valid = 1'b1;
    bus.q_ack    = 4'b0010;
    tick();
    bus.in_valid = 1'b0;
    bus.q_ack    = 4'b0000;
    checks++;
    if (bus.Q1 !== 8'h66 || bus.q_valid !== 4'b1111) begin
      errors++;
      $display("FAIL simul got Q1=%h qv=%b exp Q1=66 qv=1111", bus.Q1, bus.q_valid);
    end
    // Alias select 0010 must hit lane 0; ack of lane 3 alongside empties only lane 3.
    set_sel(4'b0010);
    bus.din      = 8'h77;
    bus.in_valid = 1'b1;
    bus.q_ack    = 4'b1001;
    tick();
    bus.in_valid = 1'b0;
    bus.q_ack    = 4'b0000;
    checks++;
    if ({bus.Q0, bus.Q1, bus.Q2, bus.Q3} !== 32'h77665544 || bus.q_valid !== 4'b0111) begin
      errors++;
      $display("FAIL alias got Q=%h qv=%b exp Q=77665544 qv=0111",
               {bus.Q0, bus.Q1, bus.Q2, bus.Q3}, bus.q_valid);
    end
    // Refill lane 3 so every lane is full again.
    set_sel(4'b1011);
    bus.din      = 8'h88;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.Q3 !== 8'h88 || bus.q_valid !== 4'b1111) begin
      errors++;
      $display("FAIL refill got Q3=%h qv=%b exp Q3=88 qv=1111", bus.Q3, bus.q_valid);
    end
  endtask

  task automatic test_flush();
    set_sel(4'b0000);
    bus.din      = 8'hAA;
    bus.in_valid = 1'b1;
    bus.q_ack    = 4'b0001;
    bus.flush    = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b exp 0", bus.in_ready);
    end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.q_ack    = 4'b0000;
    checks++;
    if ({bus.Q0, bus.Q1, bus.Q2, bus.Q3} !== 32'h0 || bus.q_valid !== 4'b0000) begin
      errors++;
      $display("FAIL flush_state got Q=%h qv=%b exp Q=00000000 qv=0000",
               {bus.Q0, bus.Q1, bus.Q2, bus.Q3}, bus.q_valid);
    end
`ifdef S2_DEMUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 8'd3) begin
      errors++;
      $display("FAIL flush_stall_cnt got %0d exp 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_spurious_ack();
    bus.q_ack = 4'b1111;
    tick();
    bus.q_ack = 4'b0000;
    checks++;
    if (bus.q_valid !== 4'b0000 || {bus.Q0, bus.Q1, bus.Q2, bus.Q3} !== 32'h0) begin
      errors++;
      $display("FAIL spurious_ack got qv=%b Q=%h exp qv=0000 Q=00000000",
               bus.q_valid, {bus.Q0, bus.Q1, bus.Q2, bus.Q3});
    end
    set_sel(4'b1011);
    bus.din      = 8'h99;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_next_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.Q3 !== 8'h99 || bus.q_valid !== 4'b1000) begin
      errors++;
      $display("FAIL spurious_next got Q3=%h qv=%b exp Q3=99 qv=1000", bus.Q3, bus.q_valid);
    end
  endtask

  task automatic test_reset_mid();
    clr = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready got %b exp 0", bus.in_ready);
    end
    tick();
    clr = 1'b1;
    checks++;
    if (bus.Q3 !== 8'h00 || bus.q_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midreset got Q3=%h qv=%b exp Q3=00 qv=0000", bus.Q3, bus.q_valid);
    end
`ifdef S2_DEMUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset_stall_cnt got %0d exp 0", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_spurious_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
